// File: rtl/video_pkg.sv
// Shared definitions for the horizontal-flip video stage: timing bit positions,
// black-level constants and the controller/output-select encodings.
package video_pkg;

  localparam int FVHT_F   = 3;
  localparam int FVHT_V   = 2;
  localparam int FVHT_H   = 1;
  localparam int FVHT_TRS = 0;

  localparam logic [9:0] BLACK_Y  = 10'h040;
  localparam logic [9:0] BLACK_C  = 10'h200;
  localparam logic [3:0] FVHT_RST = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } hflip_state_t;

  typedef enum logic [1:0] {
    SEL_PASS   = 2'd0,
    SEL_BLACK  = 2'd1,
    SEL_MIRROR = 2'd2
  } out_sel_t;

  function automatic logic [19:0] black_px();
    return {BLACK_Y, BLACK_C};
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line store: one write port, one read port with a registered
// output; both ports only advance when the clock enable is high.
module line_ram #(
  parameter int AW = 12,
  parameter int DW = 20
) (
  input  logic          clk_i,
  input  logic          cen_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // write port and registered read port
  always_ff @(posedge clk_i) begin
    if (cen_i) begin
      if (we_i) begin
        r_mem[waddr_i] <= wdata_i;
      end
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/video_hflip.sv
// Horizontal mirror of active video using ping-pong line banks; the previous
// line is read back in reverse while the current line is written.
module video_hflip
  import video_pkg::*;
#(
  parameter int MAX_ACT = 2048,
  parameter int ADDR_W  = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cen_i,
  input  logic              flip_en_i,
  input  logic [19:0]       video_i,
  input  logic [3:0]        fvht_i,
  output logic [19:0]       video_o,
  output logic [3:0]        fvht_o,
  output logic [ADDR_W:0]   line_len_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W:0] MAX_IDX = (ADDR_W+1)'(MAX_ACT);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  hflip_state_t    r_state;
  hflip_state_t    w_state_nxt;
  logic            r_act_prev;
  logic            r_v_prev;
  logic            r_wr_bank;
  logic            r_flip;
  logic [ADDR_W:0] r_wr_idx;
  logic [ADDR_W:0] r_line_len;
  logic            r_ovf;
  logic [19:0]     r_s1_video;
  logic [3:0]      r_s1_fvht;
  out_sel_t        r_s1_sel;
  logic [19:0]     r_video;
  logic [3:0]      r_fvht;

  logic            w_act;
  logic            w_act_rise;
  logic            w_act_fall;
  logic            w_v_fall;
  logic [ADDR_W:0] w_idx;
  logic            w_flip;
  logic            w_we;
  logic            w_ovf_evt;
  logic [ADDR_W-1:0] w_rd_off;
  out_sel_t        w_sel;
  logic [ADDR_W:0] w_waddr;
  logic [ADDR_W:0] w_raddr;
  logic [19:0]     w_rdata;

  assign w_act      = ~fvht_i[FVHT_V] & ~fvht_i[FVHT_H];
  assign w_act_rise = w_act & ~r_act_prev;
  assign w_act_fall = ~w_act & r_act_prev;
  assign w_v_fall   = r_v_prev & ~fvht_i[FVHT_V];

  // per-sample index, mode latch, RAM controls and output select
  always_comb begin
    w_idx     = r_wr_idx;
    w_flip    = r_flip;
    w_sel     = SEL_PASS;
    if (w_act_rise) begin
      w_idx  = '0;
      w_flip = flip_en_i;
    end else begin
      w_idx  = r_wr_idx;
      w_flip = r_flip;
    end
    w_we      = rst_ni & w_act & (w_idx < MAX_IDX);
    w_ovf_evt = w_act & (w_idx == MAX_IDX);
    w_rd_off  = ADDR_W'(r_line_len - w_idx - ONE);
    // a V-fall sample already belongs to the new frame, so it never mirrors
    if (!w_act || !w_flip) begin
      w_sel = SEL_PASS;
    end else if ((r_state == ST_RUN) && !w_v_fall && (w_idx < r_line_len)) begin
      w_sel = SEL_MIRROR;
    end else begin
      w_sel = SEL_BLACK;
    end
  end

  assign w_waddr = {r_wr_bank, w_idx[ADDR_W-1:0]};
  assign w_raddr = {~r_wr_bank, w_rd_off};

  // frame controller next state; line end is handled before a V fall
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_v_fall) w_state_nxt = ST_FIRST;
        else          w_state_nxt = ST_IDLE;
      end
      ST_FIRST: begin
        if (w_v_fall)        w_state_nxt = ST_FIRST;
        else if (w_act_fall) w_state_nxt = ST_RUN;
        else                 w_state_nxt = ST_FIRST;
      end
      ST_RUN: begin
        if (w_v_fall) w_state_nxt = ST_FIRST;
        else          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // control state: FSM, edge history, write index, bank swap, overflow flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_act_prev <= 1'b0;
      r_v_prev   <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_flip     <= 1'b0;
      r_wr_idx   <= '0;
      r_line_len <= '0;
      r_ovf      <= 1'b0;
    end else if (cen_i) begin
      r_state    <= w_state_nxt;
      r_act_prev <= w_act;
      r_v_prev   <= fvht_i[FVHT_V];
      r_flip     <= w_flip;
      if (w_act) begin
        r_wr_idx <= (w_idx == MAX_IDX) ? w_idx : (w_idx + ONE);
      end
      if (w_act_fall) begin
        r_wr_bank  <= ~r_wr_bank;
        r_line_len <= r_wr_idx;
      end
      if (w_v_fall) r_ovf <= w_ovf_evt;
      else          r_ovf <= r_ovf | w_ovf_evt;
    end
  end

  // two-stage output pipeline; stage 2 picks bypass, black or RAM data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_video <= black_px();
      r_s1_fvht  <= FVHT_RST;
      r_s1_sel   <= SEL_BLACK;
      r_video    <= black_px();
      r_fvht     <= FVHT_RST;
    end else if (cen_i) begin
      r_s1_video <= video_i;
      r_s1_fvht  <= {fvht_i[FVHT_F], fvht_i[FVHT_V], fvht_i[FVHT_H], fvht_i[FVHT_TRS]};
      r_s1_sel   <= w_sel;
      r_fvht     <= r_s1_fvht;
      case (r_s1_sel)
        SEL_PASS:   r_video <= r_s1_video;
        SEL_MIRROR: r_video <= w_rdata;
        SEL_BLACK:  r_video <= black_px();
        default:    r_video <= black_px();
      endcase
    end
  end

  line_ram #(
    .AW (ADDR_W + 1),
    .DW (20)
  ) u_line_ram (
    .clk_i   (clk_i),
    .cen_i   (cen_i),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i (video_i),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata)
  );

  assign video_o    = r_video;
  assign fvht_o     = r_fvht;
  assign line_len_o = r_line_len;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_video_hflip.sv
// Directed bench for video_hflip (MAX_ACT=16): mirroring, bypass, length
// changes, overflow, clock-enable gaps and mid-line reset.
module tb_video_hflip;

  localparam int MAX_ACT = 16;
  localparam int ADDR_W  = 4;
  localparam logic [19:0] BLK = 20'h10200;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cen_i;
  logic        flip_en_i;
  logic [19:0] video_i;
  logic [3:0]  fvht_i;
  logic [19:0] video_o;
  logic [3:0]  fvht_o;
  logic [ADDR_W:0] line_len_o;
  logic        ovf_o;

  int total = 0;
  int bad   = 0;
  int bcnt  = 0;
  bit tog   = 1'b0;
  string tag = "init";
  logic [19:0] hv [$];
  logic [3:0]  ht [$];

  video_hflip #(.MAX_ACT(MAX_ACT), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cen_i      (cen_i),
    .flip_en_i  (flip_en_i),
    .video_i    (video_i),
    .fvht_i     (fvht_i),
    .video_o    (video_o),
    .fvht_o     (fvht_o),
    .line_len_o (line_len_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] px(input int y);
    return {10'(y), 10'(y + 256)};
  endfunction

  // output at this negedge belongs to the input pushed two enabled cycles ago
  task automatic cmp_pipe();
    logic [19:0] ev;
    logic [3:0]  et;
    if (hv.size() >= 2) begin
      ev = hv[hv.size()-2];
      et = ht[ht.size()-2];
      total++;
      assert (video_o === ev) else begin
        bad++;
        $error("FAIL %s video: got %h want %h", tag, video_o, ev);
      end
      total++;
      assert (fvht_o === et) else begin
        bad++;
        $error("FAIL %s fvht: got %b want %b", tag, fvht_o, et);
      end
    end
  endtask

  task automatic step(input logic [19:0] v, input logic [3:0] t, input logic [19:0] ev);
    if (tog) begin
      @(negedge clk_i);
      cmp_pipe();
      cen_i   = 1'b0;
      video_i = 20'($urandom);
      fvht_i  = 4'($urandom);
    end
    @(negedge clk_i);
    cmp_pipe();
    rst_ni  = 1'b1;
    cen_i   = 1'b1;
    video_i = v;
    fvht_i  = t;
    hv.push_back(ev);
    ht.push_back(t);
  endtask

  task automatic hblank(input int n);
    logic [19:0] v;
    for (int i = 0; i < n; i++) begin
      v = 20'(32'h0A5A5 + bcnt * 37);
      bcnt++;
      step(v, (i == 0) ? 4'b0011 : 4'b0010, v);
    end
  endtask

  task automatic vblank(input int n);
    logic [19:0] v;
    for (int i = 0; i < n; i++) begin
      v = 20'(32'h5A5A0 + bcnt * 53);
      bcnt++;
      step(v, (i == 0) ? 4'b1111 : 4'b1110, v);
    end
  endtask

  // ec<0: bypass; otherwise first ec samples expect luma ef,ef-1,... then black
  task automatic act_line(input int n, input int y0, input int ef, input int ec, input int tog_at);
    logic [19:0] v;
    logic [19:0] e;
    for (int k = 0; k < n; k++) begin
      if (k == tog_at) flip_en_i = ~flip_en_i;
      v = px(y0 + k);
      if (ec < 0)      e = v;
      else if (k < ec) e = px(ef - k);
      else             e = BLK;
      step(v, 4'b0000, e);
    end
  endtask

  task automatic chk_len_ovf(input string name, input int len, input logic ovf);
    total++;
    assert (line_len_o === (ADDR_W+1)'(len)) else begin
      bad++;
      $error("FAIL %s line_len: got %0d want %0d", name, line_len_o, len);
    end
    total++;
    assert (ovf_o === ovf) else begin
      bad++;
      $error("FAIL %s ovf: got %b want %b", name, ovf_o, ovf);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk_i);
    cmp_pipe();
    rst_ni = 1'b0;
    cen_i  = 1'b0;
    @(negedge clk_i);
    total++;
    assert (video_o === BLK) else begin
      bad++;
      $error("FAIL %s video: got %h want %h", name, video_o, BLK);
    end
    total++;
    assert (fvht_o === 4'b0110) else begin
      bad++;
      $error("FAIL %s fvht: got %b want %b", name, fvht_o, 4'b0110);
    end
    chk_len_ovf(name, 0, 1'b0);
    rst_ni = 1'b1;
    cen_i  = 1'b0;
    hv.delete();
    ht.delete();
    repeat (2) begin
      hv.push_back(BLK);
      ht.push_back(4'b0110);
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    cen_i     = 1'b0;
    flip_en_i = 1'b1;
    video_i   = 20'h00000;
    fvht_i    = 4'b0110;
    do_reset("reset");

    tag = "idle";
    act_line(4, 0, 0, 0, -1);
    hblank(2);
    vblank(3);
    hblank(2);
    tag = "first";
    act_line(8, 0, 0, 0, -1);
    hblank(2);
    chk_len_ovf("len8", 8, 1'b0);
    tag = "ramp";
    act_line(8, 0, 7, 8, -1);
    hblank(2);
    act_line(8, 0, 7, 8, -1);
    hblank(2);
    tag = "len10";
    act_line(10, 0, 7, 8, -1);
    hblank(2);
    chk_len_ovf("len10", 10, 1'b0);
    tag = "len6";
    act_line(6, 0, 9, 6, -1);
    hblank(2);
    tag = "len12";
    act_line(12, 0, 5, 6, -1);
    hblank(2);
    chk_len_ovf("len12", 12, 1'b0);
    tag = "midflip";
    act_line(12, 0, 11, 12, 5);
    hblank(2);
    tag = "bypass";
    act_line(6, 0, 0, -1, -1);
    hblank(1);
    vblank(3);
    hblank(2);
    act_line(5, 20, 0, -1, -1);
    hblank(2);
    act_line(5, 30, 0, -1, -1);
    hblank(2);

    flip_en_i = 1'b1;
    vblank(2);
    hblank(2);
    tag = "ovf_first";
    act_line(20, 0, 0, 0, -1);
    hblank(2);
    chk_len_ovf("ovf_set", 16, 1'b1);
    tag = "ovf_mirror";
    act_line(8, 0, 15, 8, -1);
    hblank(1);
    vblank(2);
    chk_len_ovf("ovf_hold", 8, 1'b1);
    hblank(2);
    chk_len_ovf("ovf_clear", 8, 1'b0);
    tag = "ovf_next";
    act_line(8, 0, 0, 0, -1);
    hblank(2);

    tag = "cen_tog";
    tog = 1'b1;
    act_line(8, 40, 7, 8, -1);
    hblank(2);
    act_line(8, 0, 47, 8, -1);
    hblank(2);
    tog = 1'b0;

    tag = "pre_rst";
    act_line(3, 0, 7, 3, -1);
    do_reset("midline_rst");
    tag = "post_rst";
    act_line(5, 3, 0, 0, -1);
    hblank(2);
    act_line(6, 0, 0, 0, -1);
    hblank(1);
    vblank(2);
    hblank(2);
    tag = "rst_first";
    act_line(6, 0, 0, 0, -1);
    hblank(2);
    tag = "rst_resume";
    act_line(6, 0, 5, 6, -1);
    hblank(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
